alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one ALU instance between N_REQ independent requesters.
- Accepts one operation at a time by round-robin grant, drives the ALU input bus and waits a command-dependent latency.
- Captures RES and the flags, then returns them on a single response channel tagged with the requester ID.
- Sits between the command sources (testbench agents or upstream sequencers) and the ALU pin interface (CE, MODE, CIN, CMD, OPA, OPB, INP_VALID in; RES, ERR, OFLOW, COUT, G, L, E out).

Parameters:
- N_REQ, 2, number of requesters (2..8).
- OP_WIDTH, 8, operand width; RES is OP_WIDTH+1.
- CMD_WIDTH, 4, command width.
- LAT, 1, ALU result latency in cycles for non-multiply ops (>=1).
- MUL_LAT, 2, latency for multiply ops (MODE=1, CMD=9 or 10; >=1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_mode  in  N_REQ  per-requester MODE.
- req_cin  in  N_REQ  per-requester CIN.
- req_cmd  in  N_REQ*CMD_WIDTH  flattened commands; requester i at slice i.
- req_opa  in  N_REQ*OP_WIDTH  flattened OPA.
- req_opb  in  N_REQ*OP_WIDTH  flattened OPB.
- alu_ce, alu_mode, alu_cin  out  1 each  to ALU.
- alu_cmd  out  CMD_WIDTH  to ALU.
- alu_opa, alu_opb  out  OP_WIDTH each  to ALU.
- alu_inp_valid  out  2  to ALU.
- alu_res  in  OP_WIDTH+1  from ALU.
- alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1 each  from ALU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(N_REQ) (min 1)  granted requester index.
- rsp_res  out  OP_WIDTH+1  captured result.
- rsp_flags  out  6  {err,oflow,cout,g,l,e}.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, rr_ptr=0, all outputs 0, captured registers 0.
- Reset mid-operation aborts immediately. The in-flight op and any pending response are discarded and never delivered.
- IDLE:
  - Grant is the first requester with req_valid=1 searching from rr_ptr upward, with wrap-around.
  - req_ready[grant]=1 combinationally in the same cycle. The handshake completes on that edge.
  - The operands, mode, cin, cmd and grant are latched; next state ISSUE.
  - No valid requester: stay IDLE, req_ready=0.
- ISSUE (1 cycle):
  - alu_ce=1, alu_inp_valid=2'b11, alu_* driven from the latched operands.
  - Wait counter loaded with MUL_LAT if mode=1 and cmd is 9 or 10, else LAT. Next state WAIT.
- WAIT:
  - ALU inputs held, alu_ce=1, alu_inp_valid=2'b11; counter decrements each cycle.
  - On the edge where the counter expires (the Lth WAIT cycle), capture alu_res and the flags; next state RESP.
- RESP:
  - alu_ce=0, alu_inp_valid=2'b00, ALU data outputs hold their last values.
  - rsp_valid=1; rsp_id, rsp_res and rsp_flags are stable until rsp_ready=1.
  - On handshake: rr_ptr=(grant+1) mod N_REQ, next state IDLE.
  - rsp_ready may be high on RESP entry; RESP then lasts exactly 1 cycle.
- req_ready=0 in every state except IDLE. A requester dropping req_valid before grant is legal and is not served.
- Minimum turnaround per op is 3+L cycles: accept, ISSUE, L WAIT, RESP.
- alu_err is forwarded unchanged in rsp_flags[5]. The arbiter never retries an op.
- alu_ce and alu_inp_valid are 0 in IDLE and RESP.

Decomposition:
- Package alu_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, RESP};
  - constants CMD_MUL_INC=9 and CMD_MUL_SHL=10;
  - flag bit index constants FLG_ERR..FLG_E.
- Sub-module rr_arbiter (N parameter): inputs req vector and rr_ptr; outputs one-hot grant and grant index; purely combinational.

Test Plan:
- Single op, N_REQ=2: req0 MODE=1 CMD=0 OPA=8'h0F OPB=8'h01 accepted at cycle 0 -> ISSUE at cycle 1, rsp_valid at cycle 3 with rsp_id=0 and rsp_res=9'h010, rsp_ready held 1.
- Fairness: req0 and req1 continuously valid from reset -> grants alternate 0,1,0,1 for 4 ops; req_ready is never high for both at once.
- Multiply: req1 MODE=1 CMD=9 -> alu_ce high for 1+MUL_LAT=3 cycles, rsp_valid one cycle later than the ADD case, rsp_id=1.
- Backpressure: rsp_ready=0 for 5 cycles while req0 is valid -> rsp_valid, rsp_res and rsp_flags stable, req_ready=0, alu_ce=0; release -> req0 granted the next IDLE cycle.
- Reset mid-WAIT: RST=0 during WAIT -> busy, alu_ce and rsp_valid go 0 without a clock edge; after release, no response is emitted and a pending req1 is re-arbitrated from rr_ptr=0.
- Error pass-through: ALU drives alu_err=1 with alu_res=0 -> rsp_flags=6'b100000.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam int CMD_MUL_INC = 9;
   localparam int CMD_MUL_SHL = 10;

   // Bit positions inside rsp_flags = {err, oflow, cout, g, l, e}
   localparam int FLG_ERR   = 5;
   localparam int FLG_OFLOW = 4;
   localparam int FLG_COUT  = 3;
   localparam int FLG_G     = 2;
   localparam int FLG_L     = 1;
   localparam int FLG_E     = 0;
   localparam int N_FLAGS   = 6;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin accept, issue, wait a
// command-dependent latency, return the captured result tagged with requester id.
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int OP_WIDTH  = 8,
   parameter int CMD_WIDTH = 4,
   parameter int LAT       = 1,
   parameter int MUL_LAT   = 2,
   localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ-1:0]           req_mode,
   input  logic [N_REQ-1:0]           req_cin,
   input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
   input  logic [N_REQ*OP_WIDTH-1:0]  req_opa,
   input  logic [N_REQ*OP_WIDTH-1:0]  req_opb,
   output logic                       alu_ce,
   output logic                       alu_mode,
   output logic                       alu_cin,
   output logic [CMD_WIDTH-1:0]       alu_cmd,
   output logic [OP_WIDTH-1:0]        alu_opa,
   output logic [OP_WIDTH-1:0]        alu_opb,
   output logic [1:0]                 alu_inp_valid,
   input  logic [OP_WIDTH:0]          alu_res,
   input  logic                       alu_err,
   input  logic                       alu_oflow,
   input  logic                       alu_cout,
   input  logic                       alu_g,
   input  logic                       alu_l,
   input  logic                       alu_e,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IW-1:0]              rsp_id,
   output logic [OP_WIDTH:0]          rsp_res,
   output logic [N_FLAGS-1:0]         rsp_flags,
   output logic                       busy
);

   localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   arb_state_t          state;
   logic [N_REQ-1:0]    grant_oh;
   logic [IW-1:0]       grant_idx;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       id_q;
   logic [CW-1:0]       wait_cnt;
   logic [OP_WIDTH:0]   res_q;
   logic [N_FLAGS-1:0]  flags_q;
   logic                is_mul;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant_oh),
      .grant_idx (grant_idx)
   );

   // Gated by RST so no requester sees an accept while reset is asserted.
   assign req_ready     = (state == IDLE && RST) ? grant_oh : '0;
   assign alu_ce        = (state == ISSUE) || (state == WAIT);
   assign alu_inp_valid = {2{alu_ce}};
   assign rsp_valid     = (state == RESP);
   assign rsp_id        = id_q;
   assign rsp_res       = res_q;
   assign rsp_flags     = flags_q;
   assign busy          = (state != IDLE);

   assign is_mul = alu_mode && ((alu_cmd == CMD_WIDTH'(CMD_MUL_INC)) ||
                                (alu_cmd == CMD_WIDTH'(CMD_MUL_SHL)));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         id_q     <= '0;
         wait_cnt <= '0;
         res_q    <= '0;
         flags_q  <= '0;
         alu_mode <= 1'b0;
         alu_cin  <= 1'b0;
         alu_cmd  <= '0;
         alu_opa  <= '0;
         alu_opb  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  id_q     <= grant_idx;
                  alu_mode <= req_mode[grant_idx];
                  alu_cin  <= req_cin[grant_idx];
                  alu_cmd  <= req_cmd[grant_idx*CMD_WIDTH +: CMD_WIDTH];
                  alu_opa  <= req_opa[grant_idx*OP_WIDTH +: OP_WIDTH];
                  alu_opb  <= req_opb[grant_idx*OP_WIDTH +: OP_WIDTH];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= is_mul ? CW'(MUL_LAT) : CW'(LAT);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt <= CW'(1)) begin
                  res_q              <= alu_res;
                  flags_q[FLG_ERR]   <= alu_err;
                  flags_q[FLG_OFLOW] <= alu_oflow;
                  flags_q[FLG_COUT]  <= alu_cout;
                  flags_q[FLG_G]     <= alu_g;
                  flags_q[FLG_L]     <= alu_l;
                  flags_q[FLG_E]     <= alu_e;
                  state              <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rr_ptr <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a latency-aware behavioural ALU.
module tb_alu_req_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_mode = '0;
   logic [1:0]  req_cin = '0;
   logic [7:0]  req_cmd = '0;
   logic [15:0] req_opa = '0;
   logic [15:0] req_opb = '0;
   logic        alu_ce, alu_mode, alu_cin;
   logic [3:0]  alu_cmd;
   logic [7:0]  alu_opa, alu_opb;
   logic [1:0]  alu_inp_valid;
   logic [8:0]  alu_res;
   logic [5:0]  alu_flags;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [0:0]  rsp_id;
   logic [8:0]  rsp_res;
   logic [5:0]  rsp_flags;
   logic        busy;
   logic        force_err = 1'b0;
   int          ce_cnt;
   int          need;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 CLK = ~CLK;

   alu_req_arbiter dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_cin(req_cin), .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
      .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
      .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_inp_valid(alu_inp_valid),
      .alu_res(alu_res), .alu_err(alu_flags[5]), .alu_oflow(alu_flags[4]),
      .alu_cout(alu_flags[3]), .alu_g(alu_flags[2]), .alu_l(alu_flags[1]),
      .alu_e(alu_flags[0]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy)
   );

   // ALU model: the result is only valid once inputs have been held long enough.
   always @(posedge CLK or negedge RST) begin
      if (!RST) ce_cnt <= 0;
      else if (alu_ce) ce_cnt <= ce_cnt + 1;
      else ce_cnt <= 0;
   end

   always_comb begin
      alu_res   = '0;
      alu_flags = '0;
      need      = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 2 : 1;
      if (alu_mode && alu_cmd == 4'd0) begin
         alu_res      = {1'b0, alu_opa} + {1'b0, alu_opb};
         alu_flags[3] = alu_res[8];
      end else if (alu_mode && alu_cmd == 4'd9) begin
         alu_res = 9'(({1'b0, alu_opa} + 9'd1) * ({1'b0, alu_opb} + 9'd1));
      end else if (alu_mode && alu_cmd == 4'd8) begin
         alu_flags[2] = alu_opa > alu_opb;
         alu_flags[1] = alu_opa < alu_opb;
         alu_flags[0] = alu_opa == alu_opb;
      end
      if (force_err) begin
         alu_res   = '0;
         alu_flags = 6'b100000;
      end
      if (!(alu_ce && alu_inp_valid == 2'b11 && ce_cnt >= need)) begin
         alu_res   = 9'h1FF;
         alu_flags = 6'h3F;
      end
   end

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0; req_valid = '0; rsp_ready = 1'b0; force_err = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic set_req(input int id, input logic mode, input logic [3:0] cmd,
                          input logic [7:0] a, input logic [7:0] b);
      req_mode[id]       = mode;
      req_cin[id]        = 1'b0;
      req_cmd[id*4 +: 4] = cmd;
      req_opa[id*8 +: 8] = a;
      req_opb[id*8 +: 8] = b;
   endtask

   // Drives one op from requester id and waits (bounded) for its response.
   task automatic run_op(input int id, input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b,
                         output logic [8:0] res, output logic [5:0] flg,
                         output logic [0:0] rid, output int lat, output int ce_n,
                         output bit tmo);
      int k;
      tmo = 1'b0; lat = 0; ce_n = 0; k = 0;
      res = '0; flg = '0; rid = '0;
      @(negedge CLK);
      rsp_ready = 1'b1;
      set_req(id, mode, cmd, a, b);
      req_valid = '0;
      req_valid[id] = 1'b1;
      #1;
      while (req_ready[id] !== 1'b1 && k < 20) begin
         @(negedge CLK); #1; k++;
      end
      if (k >= 20) begin
         tmo = 1'b1;
         req_valid = '0;
         return;
      end
      @(negedge CLK);
      req_valid = '0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 30) begin
         if (alu_ce) ce_n++;
         @(negedge CLK);
         lat++;
      end
      if (rsp_valid !== 1'b1) tmo = 1'b1;
      res = rsp_res; flg = rsp_flags; rid = rsp_id;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RST = 1'b0; req_valid = 2'b11;
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin
         n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
      end
      n_cmp++;
      if ({busy, alu_ce, alu_inp_valid, rsp_valid} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 00000",
                           {busy, alu_ce, alu_inp_valid, rsp_valid});
      end
      n_cmp++;
      if ({rsp_id, rsp_res, rsp_flags} !== 16'h0) begin
         n_err++; $display("FAIL reset_rsp: got %h want 0000", {rsp_id, rsp_res, rsp_flags});
      end
      n_cmp++;
      if ({alu_mode, alu_cin, alu_cmd, alu_opa, alu_opb} !== 22'h0) begin
         n_err++; $display("FAIL reset_alu_bus: got %h want 0",
                           {alu_mode, alu_cin, alu_cmd, alu_opa, alu_opb});
      end
      req_valid = '0;
      do_reset();
   endtask

   task automatic test_single_op();
      logic [8:0] res; logic [5:0] flg; logic [0:0] rid; int lat, ce_n; bit tmo;
      do_reset();
      run_op(0, 1'b1, 4'd0, 8'h0F, 8'h01, res, flg, rid, lat, ce_n, tmo);
      n_cmp++;
      if (tmo || {rid, res, flg} !== {1'b0, 9'h010, 6'b0}) begin
         n_err++; $display("FAIL single_rsp: got tmo=%0d id=%0d res=%h flags=%b want id=0 res=010 flags=000000",
                           tmo, rid, res, flg);
      end
      n_cmp++;
      if (lat !== 3 || ce_n !== 2) begin
         n_err++; $display("FAIL single_timing: got lat=%0d ce=%0d want lat=3 ce=2", lat, ce_n);
      end
      n_cmp++;
      if ({alu_ce, alu_mode, alu_cmd, alu_opa, alu_opb, busy} !== {1'b0, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0}) begin
         n_err++; $display("FAIL single_hold: got ce=%b mode=%b cmd=%h opa=%h opb=%h busy=%b want 0 1 0 0f 01 0",
                           alu_ce, alu_mode, alu_cmd, alu_opa, alu_opb, busy);
      end
   endtask

   task automatic test_fairness();
      int g[4]; int n; bit both;
      n = 0; both = 1'b0;
      g = '{default: -1};
      do_reset();
      set_req(0, 1'b1, 4'd0, 8'h01, 8'h02);
      set_req(1, 1'b1, 4'd0, 8'h03, 8'h04);
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      for (int c = 0; c < 60 && n < 4; c++) begin
         #1;
         if (req_ready == 2'b11) both = 1'b1;
         else if (req_ready != 2'b00) begin
            g[n] = int'(req_ready[1]);
            n++;
         end
         @(negedge CLK);
      end
      req_valid = '0;
      n_cmp++;
      if (n != 4 || both) begin
         n_err++; $display("FAIL fair_grants: got count=%0d both=%0d want count=4 both=0", n, both);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (g[i] != i % 2) begin
            n_err++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, g[i], i % 2);
         end
      end
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_multiply();
      logic [8:0] res; logic [5:0] flg; logic [0:0] rid; int lat, ce_n; bit tmo;
      do_reset();
      run_op(1, 1'b1, 4'd9, 8'h03, 8'h04, res, flg, rid, lat, ce_n, tmo);
      n_cmp++;
      if (tmo || rid !== 1'b1 || res !== 9'h014) begin
         n_err++; $display("FAIL mul_rsp: got tmo=%0d id=%0d res=%h want id=1 res=014", tmo, rid, res);
      end
      n_cmp++;
      if (lat !== 4 || ce_n !== 3) begin
         n_err++; $display("FAIL mul_timing: got lat=%0d ce=%0d want lat=4 ce=3", lat, ce_n);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 1'b0;
      set_req(0, 1'b1, 4'd0, 8'h05, 8'h06);
      req_valid = 2'b01;
      #1;
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL bp_accept: got %b want 01", req_ready);
      end
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({rsp_valid, rsp_res, rsp_flags, req_ready, alu_ce} !== {1'b1, 9'h00B, 6'b0, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL bp_hold[%0d]: got valid=%b res=%h flags=%b ready=%b ce=%b want 1 00b 000000 00 0",
                              i, rsp_valid, rsp_res, rsp_flags, req_ready, alu_ce);
         end
         @(negedge CLK);
      end
      rsp_ready = 1'b1;
      @(negedge CLK);
      #1;
      n_cmp++;
      if ({req_ready, busy, rsp_valid} !== 4'b0100) begin
         n_err++; $display("FAIL bp_release: got ready=%b busy=%b valid=%b want 01 0 0",
                           req_ready, busy, rsp_valid);
      end
      req_valid = '0;
      @(negedge CLK);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL bp_drop: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [8:0] res; logic [5:0] flg; logic [0:0] rid; int lat, ce_n; bit tmo; bit seen; int k;
      seen = 1'b0; k = 0;
      do_reset();
      run_op(0, 1'b1, 4'd0, 8'h01, 8'h02, res, flg, rid, lat, ce_n, tmo);
      set_req(1, 1'b1, 4'd0, 8'h07, 8'h08);
      req_valid = 2'b10;
      #1;
      n_cmp++;
      if (tmo || req_ready !== 2'b10) begin
         n_err++; $display("FAIL rst_pre_grant: got tmo=%0d ready=%b want 10", tmo, req_ready);
      end
      @(negedge CLK);
      set_req(0, 1'b1, 4'd0, 8'h20, 8'h01);
      req_valid = 2'b11;
      @(negedge CLK);
      n_cmp++;
      if ({alu_ce, busy} !== 2'b11) begin
         n_err++; $display("FAIL rst_in_wait: got ce=%b busy=%b want 1 1", alu_ce, busy);
      end
      #2 RST = 1'b0;
      #1;
      n_cmp++;
      if ({busy, alu_ce, alu_inp_valid, rsp_valid} !== 5'b0) begin
         n_err++; $display("FAIL rst_async: got %b want 00000", {busy, alu_ce, alu_inp_valid, rsp_valid});
      end
      req_valid = '0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_err++; $display("FAIL rst_no_rsp: got stale activity=1 want 0");
      end
      req_valid = 2'b11;
      #1;
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL rst_rr_ptr: got %b want 01", req_ready);
      end
      @(negedge CLK);
      req_valid = '0;
      while (rsp_valid !== 1'b1 && k < 10) begin
         @(negedge CLK); k++;
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 9'h021) begin
         n_err++; $display("FAIL rst_next_op: got valid=%b id=%0d res=%h want 1 0 021",
                           rsp_valid, rsp_id, rsp_res);
      end
      @(negedge CLK);
   endtask

   task automatic test_flags();
      logic [8:0] res; logic [5:0] flg; logic [0:0] rid; int lat, ce_n; bit tmo;
      do_reset();
      run_op(0, 1'b1, 4'd8, 8'h05, 8'h06, res, flg, rid, lat, ce_n, tmo);
      n_cmp++;
      if (tmo || flg !== 6'b000010) begin
         n_err++; $display("FAIL flag_cmp: got tmo=%0d flags=%b want 000010", tmo, flg);
      end
      run_op(1, 1'b1, 4'd0, 8'hFF, 8'h01, res, flg, rid, lat, ce_n, tmo);
      n_cmp++;
      if (tmo || res !== 9'h100 || flg !== 6'b001000) begin
         n_err++; $display("FAIL flag_carry: got tmo=%0d res=%h flags=%b want 100 001000", tmo, res, flg);
      end
      force_err = 1'b1;
      run_op(0, 1'b1, 4'd0, 8'h00, 8'h00, res, flg, rid, lat, ce_n, tmo);
      force_err = 1'b0;
      n_cmp++;
      if (tmo || res !== 9'h000 || flg !== 6'b100000 || rid !== 1'b0) begin
         n_err++; $display("FAIL flag_err: got tmo=%0d res=%h flags=%b id=%0d want 000 100000 0",
                           tmo, res, flg, rid);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_fairness();
      test_multiply();
      test_backpressure();
      test_reset_mid_wait();
      test_flags();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
